// File: rtl/altitude_sampler_if.sv
// Pad-side altimeter bus and filtered-altitude outputs of altitude_sampler.
// slave = the sampler, master = whatever drives the pads and consumes the result.
interface altitude_sampler_if #(
  parameter int DATA_W = 10
) ();
  logic [DATA_W-1:0] alt_raw_i;
  logic              alt_strobe_i;
  logic [DATA_W-1:0] alt_o;
  logic              alt_valid_o;
  logic              sample_rejected_o;
  logic              fill_o;
  logic              stale_o;

  modport master (
    output alt_raw_i, alt_strobe_i,
    input  alt_o, alt_valid_o, sample_rejected_o, fill_o, stale_o
  );

  modport slave (
    input  alt_raw_i, alt_strobe_i,
    output alt_o, alt_valid_o, sample_rejected_o, fill_o, stale_o
  );
endinterface

// File: rtl/altitude_sampler.sv
// Synchronises the raw altimeter bus, rejects implausible jumps and outputs a moving average.
// Optional data-timeout flag (stale_o) is built only when ALT_STALE_TIMEOUT_EN is defined.
module altitude_sampler #(
  parameter int DATA_W       = 10,
  parameter int AVG_LOG2     = 2,
  parameter int MAX_STEP     = 64,
  parameter int REJECT_LIMIT = 3,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  altitude_sampler_if.slave bus_if
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int REJ_W = $clog2(REJECT_LIMIT + 1);
  localparam logic [DATA_W-1:0] MAX_STEP_V  = DATA_W'(MAX_STEP);
  localparam logic [REJ_W-1:0]  REJ_LIMIT_V = REJ_W'(REJECT_LIMIT);

  typedef enum logic {ST_FILL, ST_RUN} state_e;
  typedef enum logic [1:0] {RES_NONE, RES_VALID, RES_REJECT} result_e;

  // Synchronisers and edge detect
  logic              strobe_s1_q, strobe_s2_q, strobe_prev_q;
  logic [DATA_W-1:0] raw_s1_q, raw_s2_q;
  logic              strobe_rise, busy;

  // Pipeline: capture (cap_q), check (chk_q), output registers
  logic              cap_q, chk_q;
  logic [DATA_W-1:0] sample_q;
  result_e           res_q, res_d;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] win_q [N];
  logic [DATA_W-1:0] win_d [N];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d, fill_cnt_q, fill_cnt_d;
  logic [REJ_W-1:0]  rej_cnt_q, rej_cnt_d;
  logic [DATA_W-1:0] diff;
  logic              write_sample;

  logic [DATA_W-1:0] alt_q;
  logic              valid_q, rejected_q, fill_q;
  logic              valid_next;

  assign strobe_rise = strobe_s2_q & ~strobe_prev_q;
  assign busy        = cap_q | chk_q;
  assign valid_next  = chk_q && (res_q == RES_VALID);

  always_comb begin
    // NOTE: every _d gets its default first; a path that skipped one would infer a latch.
    state_d      = state_q;
    win_d        = win_q;
    sum_d        = sum_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    rej_cnt_d    = rej_cnt_q;
    res_d        = RES_NONE;
    write_sample = 1'b0;
    diff = (sample_q > alt_q) ? (sample_q - alt_q) : (alt_q - sample_q);

    if (cap_q) begin
      unique case (state_q)
        ST_FILL: begin
          write_sample = 1'b1;
          fill_cnt_d   = fill_cnt_q + AVG_LOG2'(1);
          if (&fill_cnt_q) begin
            state_d = ST_RUN;
            res_d   = RES_VALID;
          end
        end
        ST_RUN: begin
          if (diff <= MAX_STEP_V) begin
            write_sample = 1'b1;
            rej_cnt_d    = '0;
            res_d        = RES_VALID;
          end else if (rej_cnt_q + REJ_W'(1) < REJ_LIMIT_V) begin
            rej_cnt_d = rej_cnt_q + REJ_W'(1);
            res_d     = RES_REJECT;
          end else begin
            // Too many consecutive outliers: trust the sensor and restart from this sample
            win_d     = '{default: sample_q};
            sum_d     = {sample_q, {AVG_LOG2{1'b0}}};
            rej_cnt_d = '0;
            res_d     = RES_VALID;
          end
        end
        default: state_d = ST_FILL;
      endcase

      if (write_sample) begin
        win_d[wr_ptr_q] = sample_q;
        sum_d    = sum_q - SUM_W'(win_q[wr_ptr_q]) + SUM_W'(sample_q);
        wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      strobe_s1_q   <= 1'b0;
      strobe_s2_q   <= 1'b0;
      strobe_prev_q <= 1'b0;
      raw_s1_q      <= '0;
      raw_s2_q      <= '0;
      cap_q         <= 1'b0;
      chk_q         <= 1'b0;
      sample_q      <= '0;
      res_q         <= RES_NONE;
      state_q       <= ST_FILL;
      // NOTE: the window itself is cleared, not just the pointer: FILL reuses
      // sum - oldest + sample and depends on the old entries being zero.
      win_q         <= '{default: '0};
      sum_q         <= '0;
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      rej_cnt_q     <= '0;
      alt_q         <= '0;
      valid_q       <= 1'b0;
      rejected_q    <= 1'b0;
      fill_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so each register sees the pre-edge values of the others.
      strobe_s1_q   <= bus_if.alt_strobe_i;
      strobe_s2_q   <= strobe_s1_q;
      strobe_prev_q <= strobe_s2_q;
      raw_s1_q      <= bus_if.alt_raw_i;
      raw_s2_q      <= raw_s1_q;

      cap_q <= strobe_rise & ~busy;
      if (strobe_rise && !busy) sample_q <= raw_s2_q;
      chk_q <= cap_q;
      res_q <= res_d;

      state_q    <= state_d;
      win_q      <= win_d;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      rej_cnt_q  <= rej_cnt_d;

      valid_q    <= valid_next;
      rejected_q <= chk_q && (res_q == RES_REJECT);
      if (valid_next) begin
        alt_q  <= sum_q[SUM_W-1:AVG_LOG2];
        fill_q <= 1'b1;
      end
    end
  end

  assign bus_if.alt_o             = alt_q;
  assign bus_if.alt_valid_o       = valid_q;
  assign bus_if.sample_rejected_o = rejected_q;
  assign bus_if.fill_o            = fill_q;

`ifdef ALT_STALE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             stale_q;

  // Cleared alongside the valid pulse so stale_o drops in the same cycle alt_valid_o rises
  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      stale_q   <= 1'b1;
    end else if (valid_next) begin
      tmo_cnt_q <= '0;
      stale_q   <= 1'b0;
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (tmo_cnt_q == TMO_MAX - TMO_W'(1)) stale_q <= 1'b1;
    end
  end

  assign bus_if.stale_o = stale_q;
`else
  // Constant 0; the expression only keeps TIMEOUT_CYC referenced in this build
  assign bus_if.stale_o = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_altitude_sampler.sv
// Randomised bench for altitude_sampler: a cycle-timed behavioural model of the
// sampling/averaging rules plus directed literal checks of the fill/slide/reject/resync scenarios.
module tb_altitude_sampler;

  localparam int DATA_W       = 10;
  localparam int AVG_LOG2     = 2;
  localparam int N            = 4;
  localparam int MAX_STEP     = 64;
  localparam int REJECT_LIMIT = 3;
  localparam int TIMEOUT_CYC  = 1000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  altitude_sampler_if #(.DATA_W(DATA_W)) bus_if ();

  altitude_sampler #(
    .DATA_W      (DATA_W),
    .AVG_LOG2    (AVG_LOG2),
    .MAX_STEP    (MAX_STEP),
    .REJECT_LIMIT(REJECT_LIMIT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus_if(bus_if.slave)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timing rules: a strobe rise first seen at clock edge e is captured at e+2
  // (unless a sample was captured fewer than 3 edges earlier), and its result
  // appears on the outputs from edge e+4.
  int  cyc = 0;
  bit  started = 1'b0;
  bit  m_prev;
  bit  edge_pend;   int edge_cap_at; int edge_raw;
  bit  out_pend;    int out_at;      int out_raw;
  int  last_cap;
  int  mwin [N];
  int  mwr, mfill, mrej;
  bit  mrun;
  int  exp_alt;
  bit  exp_valid, exp_rej, exp_fill, exp_stale;
  int  mtmo;

  function automatic int win_avg();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += mwin[i];
    return s / N;
  endfunction

  task automatic model_sample(input int s);
    int d;
    if (!mrun) begin
      mwin[mwr] = s;
      mwr = (mwr + 1) % N;
      mfill++;
      if (mfill == N) begin
        mrun = 1'b1;
        exp_alt = win_avg();
        exp_valid = 1'b1;
        exp_fill = 1'b1;
      end
    end else begin
      d = s - exp_alt;
      if (d < 0) d = -d;
      if (d <= MAX_STEP) begin
        mwin[mwr] = s;
        mwr = (mwr + 1) % N;
        exp_alt = win_avg();
        exp_valid = 1'b1;
        mrej = 0;
      end else if (mrej + 1 < REJECT_LIMIT) begin
        mrej++;
        exp_rej = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) mwin[i] = s;
        exp_alt = s;
        exp_valid = 1'b1;
        mrej = 0;
      end
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    started = 1'b1;
    exp_valid = 1'b0;
    exp_rej = 1'b0;
    if (!reset) begin
      m_prev = 1'b0;
      edge_pend = 1'b0;
      out_pend = 1'b0;
      last_cap = -100;
      for (int i = 0; i < N; i++) mwin[i] = 0;
      mwr = 0; mfill = 0; mrej = 0; mrun = 1'b0;
      exp_alt = 0;
      exp_fill = 1'b0;
      mtmo = 0;
`ifdef ALT_STALE_TIMEOUT_EN
      exp_stale = 1'b1;
`else
      exp_stale = 1'b0;
`endif
    end else begin
      if (out_pend && out_at == cyc) begin
        out_pend = 1'b0;
        model_sample(out_raw);
      end
      if (edge_pend && edge_cap_at == cyc) begin
        edge_pend = 1'b0;
        if (cyc - last_cap >= 3) begin
          last_cap = cyc;
          out_pend = 1'b1;
          out_at = cyc + 2;
          out_raw = edge_raw;
        end
      end
      if (bus_if.alt_strobe_i && !m_prev) begin
        edge_pend = 1'b1;
        edge_cap_at = cyc + 2;
        edge_raw = int'(bus_if.alt_raw_i);
      end
      m_prev = bus_if.alt_strobe_i;
`ifdef ALT_STALE_TIMEOUT_EN
      if (exp_valid) begin
        mtmo = 0;
        exp_stale = 1'b0;
      end else if (mtmo < TIMEOUT_CYC) begin
        mtmo++;
        if (mtmo == TIMEOUT_CYC) exp_stale = 1'b1;
      end
`endif
    end
  end

  // ---------------- compare process ----------------
  int dut_valid_cnt = 0;
  int dut_rej_cnt = 0;

  always @(negedge clock) begin
    if (started) begin
      check("alt_o",             bus_if.alt_o,             exp_alt);
      check("alt_valid_o",       bus_if.alt_valid_o,       exp_valid);
      check("sample_rejected_o", bus_if.sample_rejected_o, exp_rej);
      check("fill_o",            bus_if.fill_o,            exp_fill);
      check("stale_o",           bus_if.stale_o,           exp_stale);
      if (bus_if.alt_valid_o === 1'b1) dut_valid_cnt++;
      if (bus_if.sample_rejected_o === 1'b1) dut_rej_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int value, input int hold, input int gap);
    @(negedge clock);
    bus_if.alt_raw_i    = DATA_W'(value);
    bus_if.alt_strobe_i = 1'b1;
    repeat (hold) @(negedge clock);
    bus_if.alt_strobe_i = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    bus_if.alt_strobe_i = 1'b0;
    reset = 1'b0;
    repeat (cycles) @(negedge clock);
    reset = 1'b1;
  endtask

  int v0, r0;

  initial begin
    bus_if.alt_raw_i    = '0;
    bus_if.alt_strobe_i = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_alt",   bus_if.alt_o, 0);
    check("reset_fill",  bus_if.fill_o, 0);
    check("reset_valid", bus_if.alt_valid_o, 0);

    // Fill
    v0 = dut_valid_cnt;
    send(100, 2, 6); send(104, 2, 6); send(108, 2, 6);
    check("fill_no_valid", dut_valid_cnt - v0, 0);
    check("fill_not_full", bus_if.fill_o, 0);
    send(112, 2, 6);
    check("fill_avg",       bus_if.alt_o, 106);
    check("fill_model_avg", exp_alt, 106);
    check("fill_flag",      bus_if.fill_o, 1);
    check("fill_one_valid", dut_valid_cnt - v0, 1);

    // Slide
    send(116, 2, 6);
    check("slide_avg", bus_if.alt_o, 110);

    // Reject then accept
    r0 = dut_rej_cnt; v0 = dut_valid_cnt;
    send(300, 2, 6);
    check("reject_pulse", dut_rej_cnt - r0, 1);
    check("reject_hold",  bus_if.alt_o, 110);
    check("reject_no_valid", dut_valid_cnt - v0, 0);
    send(114, 2, 6);
    check("after_reject_avg", bus_if.alt_o, 112);

    // Resync
    r0 = dut_rej_cnt; v0 = dut_valid_cnt;
    send(500, 2, 6); send(500, 2, 6); send(500, 2, 6);
    check("resync_rejects", dut_rej_cnt - r0, 2);
    check("resync_valid",   dut_valid_cnt - v0, 1);
    check("resync_alt",     bus_if.alt_o, 500);
    send(504, 2, 6);
    check("post_resync_avg", bus_if.alt_o, 501);
    send(565, 2, 6);
    check("step_equal_accept", bus_if.alt_o, 517);
    check("step_equal_model",  exp_alt, 517);

    // Strobe held high: one sample only
    v0 = dut_valid_cnt;
    send(520, 50, 6);
    check("held_one_sample", dut_valid_cnt - v0, 1);
    check("held_avg",        bus_if.alt_o, 522);

    // Second edge two clocks after the first is dropped
    v0 = dut_valid_cnt;
    @(negedge clock);
    bus_if.alt_raw_i = DATA_W'(530);
    bus_if.alt_strobe_i = 1'b1;
    @(negedge clock) bus_if.alt_strobe_i = 1'b0;
    @(negedge clock) bus_if.alt_strobe_i = 1'b1;
    @(negedge clock) bus_if.alt_strobe_i = 1'b0;
    repeat (8) @(negedge clock);
    check("busy_drop", dut_valid_cnt - v0, 1);
    check("busy_avg",  bus_if.alt_o, 529);

    // Reset three clocks after a strobe discards the sample
    v0 = dut_valid_cnt;
    @(negedge clock);
    bus_if.alt_raw_i = DATA_W'(540);
    bus_if.alt_strobe_i = 1'b1;
    @(negedge clock) bus_if.alt_strobe_i = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("midreset_no_valid", dut_valid_cnt - v0, 0);
    check("midreset_alt",      bus_if.alt_o, 0);
    check("midreset_fill",     bus_if.fill_o, 0);
    send(200, 2, 6); send(204, 2, 6); send(208, 2, 6); send(212, 2, 6);
    check("refill_avg",  bus_if.alt_o, 206);
    check("refill_flag", bus_if.fill_o, 1);

`ifdef ALT_STALE_TIMEOUT_EN
    check("stale_clear", bus_if.stale_o, 0);
    repeat (TIMEOUT_CYC + 10) @(negedge clock);
    check("stale_set", bus_if.stale_o, 1);
    send(900, 2, 6);
    check("stale_reject_keeps", bus_if.stale_o, 1);
    send(210, 2, 6);
    check("stale_valid_clears", bus_if.stale_o, 0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      int v;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45)      v = exp_alt + int'($urandom_range(0, 140)) - 70;
      else if (r < 55) v = exp_alt + MAX_STEP + int'($urandom_range(0, 1));
      else if (r < 65) v = exp_alt - MAX_STEP - int'($urandom_range(0, 1));
      else             v = int'($urandom_range(0, 1023));
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      if (r >= 97) do_reset(int'($urandom_range(1, 3)));
      send(v, int'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
    end

    repeat (10) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/altitude_sampler.md
Name: altitude_sampler

Overview:
- Upstream conditioning stage for the autopilot (oto_pilot). Takes the raw parallel altimeter bus and data strobe from the user IO pads, in the wb_clk_i domain.
- Synchronises the inputs, captures one sample per strobe edge and rejects implausible jumps.
- Keeps a power-of-two moving average and presents a filtered altitude with a one-cycle valid pulse to the autopilot's altitude input.

Parameters:
- DATA_W, 10: altitude sample width.
- AVG_LOG2, 2: log2 of averaging window depth; N = 2^AVG_LOG2 = 4.
- MAX_STEP, 64: largest accepted |sample - alt_o| in RUN state.
- REJECT_LIMIT, 3: consecutive rejects that force a resync.
- TIMEOUT_CYC, 1000000: clocks without a valid output before stale_o is set. Used only with the optional feature.

Ports:
- clock, input, 1: system clock (wb_clk_i).
- reset, input, 1: synchronous, active-low reset (0 = reset).
- alt_raw_i, input, DATA_W: raw altimeter bus from pads; asynchronous.
- alt_strobe_i, input, 1: sample-ready strobe from pads; asynchronous, rising edge marks new data.
- alt_o, output, DATA_W: filtered altitude, registered.
- alt_valid_o, output, 1: one-cycle pulse when alt_o is updated.
- sample_rejected_o, output, 1: one-cycle pulse per rejected sample.
- fill_o, output, 1: high once the averaging window has been filled.
- stale_o, output, 1: data-timeout flag; see Optional Feature.

Behaviour:
- Input sync: both alt_strobe_i and alt_raw_i pass through 2-flop synchronisers.
- Edge detect: one pulse per synchronised strobe rising edge. A strobe held high produces one edge only. The sensor guarantees the data bus is stable for 3 clocks around the edge.
- Pipeline, with edge 0 being the first clock edge that samples alt_strobe_i high:
  - edge 2: sample captured.
  - edge 3: plausibility check and sum update.
  - edge 4: alt_o / alt_valid_o / sample_rejected_o registered; outputs visible in the cycle after edge 4.
- Busy rule: one sample in flight at a time. An edge detected while a sample is in flight is dropped silently.
- Storage: circular buffer of N entries, write pointer wraps modulo N. Running sum is DATA_W+AVG_LOG2 bits and cannot overflow.
- Average: alt_o = sum >> AVG_LOG2, truncating.
- FSM states: FILL, RUN.
- FILL:
  - No plausibility check; every sample is written and the fill count increments.
  - No alt_valid_o on the first N-1 samples.
  - On the Nth sample: alt_o = average, alt_valid_o pulses, fill_o is set, state goes to RUN.
- RUN, per sample, with d = |sample - alt_o|:
  - d <= MAX_STEP (equality accepted): accept. Oldest entry is replaced, sum = sum - oldest + sample, alt_o updated, alt_valid_o pulses, reject count cleared.
  - d > MAX_STEP and reject count + 1 < REJECT_LIMIT: reject. sample_rejected_o pulses, reject count increments, buffer/sum/alt_o unchanged, no alt_valid_o.
  - d > MAX_STEP and reject count + 1 == REJECT_LIMIT: resync. All entries = sample, sum = sample << AVG_LOG2, alt_o = sample, alt_valid_o pulses, sample_rejected_o does not pulse, reject count cleared. State remains RUN.
- Reset (reset = 0 at a clock edge):
  - alt_o = 0; alt_valid_o, sample_rejected_o and fill_o = 0.
  - Buffer, sum, pointer and counts cleared; synchronisers cleared; state = FILL.
  - In-flight sample discarded.
  - stale_o = 1 with the feature, 0 without.
- Reset mid-operation: identical to power-up reset. No pulse is emitted for a discarded sample.

Optional Feature:
- Macro: ALT_STALE_TIMEOUT_EN.
- Defined:
  - A saturating counter clears on every alt_valid_o and increments otherwise.
  - stale_o is set when the counter reaches TIMEOUT_CYC.
  - stale_o is cleared in the same cycle alt_valid_o is high.
  - Rejected samples do not clear the counter.
- Undefined: no counter is built; stale_o is constant 0.

Test Plan:
- Fill: reset, then strobes with 100, 104, 108, 112 -> no valid on the first three; on the fourth, alt_o = 106, fill_o = 1, and a single alt_valid_o pulse in the cycle after edge 4.
- Slide: then strobe 116 -> oldest 100 replaced, alt_o = 110, valid pulse.
- Reject: strobe 300 (d = 190) -> sample_rejected_o pulse, alt_o stays 110, no valid. Then strobe 114 -> alt_o = (108+112+116+114)/4 = 112, valid.
- Resync: three strobes of 500 -> two reject pulses, then on the third alt_o = 500 with valid and no reject pulse. Then strobe 504 -> alt_o = 501. Then 565 (d = 64) -> accepted.
- Timing: strobe held high 50 clocks -> exactly one sample. Second edge 2 clocks after the first -> dropped. Reset driven low 3 clocks after a strobe -> no valid, alt_o = 0, fill_o = 0, FILL restarts.
- Stale (ALT_STALE_TIMEOUT_EN, TIMEOUT_CYC = 1000): stale_o = 1 after reset and clears on the first valid. With no strobes for 1000 clocks, stale_o rises. A rejected sample leaves it set; the next valid clears it in the same cycle.
